// File: rtl/mainbus_arbiter.sv
// Main-bus arbiter between the CPU pipeline and one external DMA/debug requester.
// Optional statistics outputs are enabled by defining ARB_STATS_EN.
module mainbus_arbiter #(
  parameter int unsigned HOLD_MAX   = 8,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned WAIT_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_bus_request,
  input  logic        cpu_break,
  input  logic        dma_req,
  output logic        cpu_grant,
  output logic        dma_grant,
  output logic        pipeline_stall,
`ifdef ARB_STATS_EN
  output logic [15:0] stat_dma_cycles,
  output logic [7:0]  stat_forced,
`endif
  output logic        bus_idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_DMA,
    S_TURN
  } state_e;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX - 1);
  localparam logic [1:0] TURN_LIM = 2'(TURNAROUND - 1);

  state_e     state_q, state_d;
  logic       turn_to_dma_q, turn_to_dma_d;
  logic [1:0] turn_cnt_q, turn_cnt_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] hold_q, hold_d;
  logic       cpu_grant_q, dma_grant_q;

  always_comb begin
    state_d       = state_q;
    turn_to_dma_d = turn_to_dma_q;
    turn_cnt_d    = turn_cnt_q;
    wait_d        = wait_q;
    hold_d        = hold_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_bus_request) state_d = S_CPU;
        else if (dma_req)    state_d = S_DMA;
      end

      S_CPU: begin
        if (dma_req && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
        if (!cpu_bus_request) begin
          if (dma_req) begin
            state_d       = S_TURN;
            turn_to_dma_d = 1'b1;
            turn_cnt_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (dma_req && wait_q >= WAIT_LIM) begin
          state_d       = S_TURN;
          turn_to_dma_d = 1'b1;
          turn_cnt_d    = '0;
        end
      end

      S_DMA: begin
        if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
        // Break suppresses the tenure limit so a debugger keeps the bus indefinitely.
        if (!dma_req) begin
          if (cpu_bus_request) begin
            state_d       = S_TURN;
            turn_to_dma_d = 1'b0;
            turn_cnt_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cpu_bus_request && !cpu_break && hold_q >= HOLD_LIM) begin
          state_d       = S_TURN;
          turn_to_dma_d = 1'b0;
          turn_cnt_d    = '0;
        end
      end

      S_TURN: begin
        if (turn_cnt_q == TURN_LIM) begin
          if (turn_to_dma_q) state_d = dma_req ? S_DMA : S_IDLE;
          else               state_d = cpu_bus_request ? S_CPU : S_IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DMA)                        wait_d = '0;
    if (state_d == S_CPU || state_d == S_IDLE)   hold_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      turn_to_dma_q <= 1'b0;
      turn_cnt_q    <= '0;
      wait_q        <= '0;
      hold_q        <= '0;
      cpu_grant_q   <= 1'b0;
      dma_grant_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      turn_to_dma_q <= turn_to_dma_d;
      turn_cnt_q    <= turn_cnt_d;
      wait_q        <= wait_d;
      hold_q        <= hold_d;
      cpu_grant_q   <= (state_d == S_CPU);
      dma_grant_q   <= (state_d == S_DMA);
    end
  end

  assign cpu_grant      = cpu_grant_q;
  assign dma_grant      = dma_grant_q;
  assign bus_idle       = ~(cpu_grant_q | dma_grant_q);
  assign pipeline_stall = cpu_bus_request & ~cpu_grant_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_dma_q, stat_dma_d;
  logic [7:0]  stat_forced_q, stat_forced_d;
  logic        forced_handover;

  // Forced only when the CPU still wants the bus; a voluntary drop is not counted.
  assign forced_handover = (state_q == S_CPU) & cpu_bus_request & dma_req &
                           (wait_q >= WAIT_LIM);

  always_comb begin
    stat_dma_d    = stat_dma_q;
    stat_forced_d = stat_forced_q;
    if (dma_grant_q) stat_dma_d = stat_dma_q + 16'd1;
    if (forced_handover && stat_forced_q != 8'hFF) stat_forced_d = stat_forced_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_dma_q    <= '0;
      stat_forced_q <= '0;
    end else begin
      stat_dma_q    <= stat_dma_d;
      stat_forced_q <= stat_forced_d;
    end
  end

  assign stat_dma_cycles = stat_dma_q;
  assign stat_forced     = stat_forced_q;
`endif

endmodule

// File: tb/tb_mainbus_arbiter.sv
// Self-checking bench for mainbus_arbiter: directed scenarios plus random traffic
// compared against an owner/tenure reference model.
module tb_mainbus_arbiter;

  localparam int HOLD_MAX   = 8;
  localparam int TURNAROUND = 1;
  localparam int WAIT_MAX   = 16;

  localparam int O_IDLE = 0;
  localparam int O_CPU  = 1;
  localparam int O_DMA  = 2;
  localparam int O_TURN = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req, brk, dma;
  logic cpu_grant, dma_grant, stall, idle;
`ifdef ARB_STATS_EN
  logic [15:0] stat_dma;
  logic [7:0]  stat_forced;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: who owns the bus and how long each party has been at it
  int m_owner, m_next, m_tleft, m_wait, m_hold, m_dmacyc, m_forced;

  // last observed outputs
  logic obs_cpu, obs_dma, obs_idle, obs_stall;
  int   n_cpu, n_dma, n_stall;

  always #5 clk = ~clk;

  mainbus_arbiter #(
    .HOLD_MAX  (HOLD_MAX),
    .TURNAROUND(TURNAROUND),
    .WAIT_MAX  (WAIT_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_bus_request(cpu_req),
    .cpu_break      (brk),
    .dma_req        (dma),
    .cpu_grant      (cpu_grant),
    .dma_grant      (dma_grant),
    .pipeline_stall (stall),
`ifdef ARB_STATS_EN
    .stat_dma_cycles(stat_dma),
    .stat_forced    (stat_forced),
`endif
    .bus_idle       (idle)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = O_IDLE;
    m_next   = O_IDLE;
    m_tleft  = 0;
    m_wait   = 0;
    m_hold   = 0;
    m_dmacyc = 0;
    m_forced = 0;
  endtask

  task automatic enter(input int who);
    m_owner = who;
    if (who == O_DMA) m_wait = 0;
    if (who == O_CPU || who == O_IDLE) m_hold = 0;
  endtask

  task automatic start_turn(input int who);
    m_owner = O_TURN;
    m_next  = who;
    m_tleft = TURNAROUND;
  endtask

  task automatic model_step(input logic c, input logic b, input logic d);
    int seen;
    if (m_owner == O_DMA) m_dmacyc = (m_dmacyc + 1) % 65536;
    case (m_owner)
      O_IDLE: begin
        if (c)      enter(O_CPU);
        else if (d) enter(O_DMA);
      end
      O_CPU: begin
        seen   = m_wait + (d ? 1 : 0);
        m_wait = seen;
        if (!c) begin
          if (d) start_turn(O_DMA);
          else   enter(O_IDLE);
        end else if (d && seen >= WAIT_MAX) begin
          start_turn(O_DMA);
          if (m_forced < 255) m_forced++;
        end
      end
      O_DMA: begin
        m_hold++;
        if (!d) begin
          if (c) start_turn(O_CPU);
          else   enter(O_IDLE);
        end else if (c && !b && m_hold >= HOLD_MAX) begin
          start_turn(O_CPU);
        end
      end
      default: begin
        m_tleft--;
        if (m_tleft == 0) begin
          if ((m_next == O_DMA) ? d : c) enter(m_next);
          else                           enter(O_IDLE);
        end
      end
    endcase
  endtask

  // Drive one clock of inputs, check mid-cycle, then advance the model at the edge.
  task automatic step_cycle(input logic c, input logic b, input logic d);
    cpu_req = c;
    brk     = b;
    dma     = d;
    @(negedge clk);
    obs_cpu   = cpu_grant;
    obs_dma   = dma_grant;
    obs_idle  = idle;
    obs_stall = stall;
    if (obs_cpu)   n_cpu++;
    if (obs_dma)   n_dma++;
    if (obs_stall) n_stall++;
    chk("cpu_grant", cpu_grant, 16'(m_owner == O_CPU));
    chk("dma_grant", dma_grant, 16'(m_owner == O_DMA));
    chk("bus_idle", idle, 16'(m_owner == O_IDLE || m_owner == O_TURN));
    chk("pipeline_stall", stall, 16'(c && m_owner != O_CPU));
`ifdef ARB_STATS_EN
    chk("stat_dma_cycles", stat_dma, 16'(m_dmacyc));
    chk("stat_forced", 16'(stat_forced), 16'(m_forced));
`endif
    @(posedge clk);
    model_step(c, b, d);
    #1;
  endtask

  // Called just after a rising edge; reset is asserted and released before the next edge.
  task automatic do_reset(input logic c, input logic b, input logic d);
    cpu_req = c;
    brk     = b;
    dma     = d;
    rst_n   = 1'b0;
    #1;
    chk("rst_cpu_grant", cpu_grant, 16'd0);
    chk("rst_dma_grant", dma_grant, 16'd0);
    chk("rst_bus_idle", idle, 16'd1);
    chk("rst_stall", stall, 16'(c));
    model_reset();
    #2;
    rst_n = 1'b1;
    n_cpu   = 0;
    n_dma   = 0;
    n_stall = 0;
  endtask

  initial begin
    logic c, b, d;
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    brk     = 1'b0;
    dma     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // CPU request from the first cycle after reset
    do_reset(1'b1, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b0);
    chk("t1_stall_c0", 16'(obs_stall), 16'd1);
    chk("t1_grant_c0", 16'(obs_cpu), 16'd0);
    step_cycle(1'b1, 1'b0, 1'b0);
    chk("t1_grant_c1", 16'(obs_cpu), 16'd1);
    chk("t1_stall_c1", 16'(obs_stall), 16'd0);

    // simultaneous requests: CPU first, then turnaround to DMA
    do_reset(1'b0, 1'b0, 1'b0);
    repeat (3) step_cycle(1'b1, 1'b0, 1'b1);
    step_cycle(1'b0, 1'b0, 1'b1);
    chk("t2_cpu_cycles", 16'(n_cpu), 16'd3);
    step_cycle(1'b0, 1'b0, 1'b1);
    chk("t2_turn_idle", 16'(obs_idle), 16'd1);
    step_cycle(1'b0, 1'b0, 1'b1);
    chk("t2_dma_grant", 16'(obs_dma), 16'd1);

    // DMA tenure bounded by HOLD_MAX while the CPU waits
    do_reset(1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b1);
    n_dma = 0; n_stall = 0;
    repeat (12) step_cycle(1'b1, 1'b0, 1'b1);
    chk("t3_dma_cycles", 16'(n_dma), 16'(HOLD_MAX));
    chk("t3_stall_cycles", 16'(n_stall), 16'(HOLD_MAX + TURNAROUND));
    chk("t3_cpu_grant", 16'(obs_cpu), 16'd1);

    // break disables the tenure limit
    do_reset(1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b1, 1'b1);
    n_dma = 0;
    repeat (40) step_cycle(1'b1, 1'b1, 1'b1);
    chk("t4_dma_cycles", 16'(n_dma), 16'd40);
    step_cycle(1'b1, 1'b1, 1'b0);
    chk("t4_dma_last", 16'(obs_dma), 16'd1);
    step_cycle(1'b1, 1'b1, 1'b0);
    chk("t4_turn_idle", 16'(obs_idle), 16'd1);
    step_cycle(1'b1, 1'b1, 1'b0);
    chk("t4_cpu_grant", 16'(obs_cpu), 16'd1);

    // forced handover after WAIT_MAX waiting cycles
    do_reset(1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b0);
    n_cpu = 0;
    repeat (20) step_cycle(1'b1, 1'b0, 1'b1);
    chk("t5_cpu_cycles", 16'(n_cpu), 16'(WAIT_MAX));
    chk("t5_dma_grant", 16'(obs_dma), 16'd1);
`ifdef ARB_STATS_EN
    chk("t5_stat_forced", 16'(stat_forced), 16'd1);
`endif

    // asynchronous reset mid DMA tenure with a pending CPU request
    do_reset(1'b0, 1'b0, 1'b0);
    repeat (3) step_cycle(1'b0, 1'b0, 1'b1);
    chk("t6_dma_before", 16'(obs_dma), 16'd1);
    do_reset(1'b1, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b0);
    chk("t6_cpu_c0", 16'(obs_cpu), 16'd0);
    step_cycle(1'b1, 1'b0, 1'b0);
    chk("t6_cpu_c1", 16'(obs_cpu), 16'd1);

    // random traffic against the model
    do_reset(1'b0, 1'b0, 1'b0);
    c = 1'b0; b = 1'b0; d = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0)  c = ~c;
      if ($urandom_range(0, 7) == 0)  d = ~d;
      if ($urandom_range(0, 29) == 0) b = ~b;
      if ($urandom_range(0, 249) == 0) do_reset(c, b, d);
      step_cycle(c, b, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
